mac_operand_feeder: RTL and testbench
=====================================

# mac_operand_feeder

Streaming operand feeder that drives an N×N systolic array of MAC PEs from the edge. It accepts one N-wide vector of `a` operands and one of `b` operands per beat through a valid/ready handshake. It re-times lane i by i cycles (diagonal wavefront skew) and zero-fills bubbles. It also asserts a per-lane tile-clear so each PE accumulator restarts on the first beat of a tile.

## Interface
- `W`, 16: operand width in bits, signed two's complement.
- `N`, 4: array dimension; number of row lanes and column lanes.
- `LW`, 8: width of the tile-length field.

- `clk`  in  1  single clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a tile; sampled only in IDLE.
- `len`  in  LW  tile length K in beats; latched on accepted `start`.
- `in_valid`  in  1  `a_vec`/`b_vec` carry a beat.
- `in_ready`  out  1  feeder accepts a beat this cycle.
- `a_vec`  in  N*W  row operands; lane i at `[(i+1)*W-1 -: W]`.
- `b_vec`  in  N*W  column operands; same packing.
- `a_row`  out  N*W  skewed row operands to array west edge.
- `b_col`  out  N*W  skewed column operands to array north edge.
- `lane_valid`  out  N  lane i carries a real beat.
- `pe_clr`  out  N  lane i carries the first beat of the tile.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse when the last beat leaves lane N-1.

## Operation
- States: IDLE, STREAM, FLUSH, DONE.
- IDLE:
  - `start`=1 with `len`≠0: latch K=`len`, clear the beat counter, go to STREAM.
  - `start` with `len`=0: ignored; stay in IDLE.
- STREAM:
  - `in_ready`=1.
  - A beat is accepted when `in_valid && in_ready`; the beat counter increments.
  - When the K-th beat is accepted, go to FLUSH. If N=1, go directly to DONE.
  - When `in_valid`=0, a bubble is injected: data forced to 0, valid=0, clr=0.
- FLUSH:
  - `in_ready`=0. Bubbles are injected for exactly N-1 cycles, counted by a clog2(N)-bit counter.
  - Then go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE. `start` is ignored in DONE.
- Skew pipeline:
  - Lane i has a shift chain of i+1 registers carrying {a, b, valid, clr}.
  - The chains shift every cycle unconditionally. There is no backpressure from the array.
- `pe_clr` is tagged onto the first accepted beat of a tile only. It travels with that beat down every lane.
- Output data is zero whenever the corresponding `lane_valid`=0. PEs therefore accumulate 0 on bubbles.
- No arithmetic is performed on operands; they pass bit-exact. The beat counter is LW bits and compares for equality with K, so it never wraps.
- Reset (async, at any time including mid-tile):
  - State goes to IDLE and all pipeline registers clear.
  - Outputs: `a_row`=0, `b_col`=0, `lane_valid`=0, `pe_clr`=0, `in_ready`=0, `busy`=0, `done`=0.
  - A partially streamed tile is discarded.

## Timing
- `start` sampled high in IDLE at cycle t: STREAM from t+1, and `in_ready` rises at t+1.
- Beat accepted at cycle c: appears on lane i outputs during cycle c+1+i.
- Last beat accepted at cycle L:
  - FLUSH during L+1 … L+N-1.
  - DONE (`done`=1) at L+N, coinciding with the last beat on lane N-1.
  - IDLE at L+N+1.
- Minimum tile occupancy is K+N+1 cycles from `start` to IDLE.
- Back-to-back tiles: the next `start` is accepted at the earliest in cycle L+N+1.

## Configuration
- `MAC_FEEDER_SKEW_EN` defined:
  - Lane i delay is i+1 cycles, as above.
  - FLUSH lasts N-1 cycles.
- Not defined:
  - Every lane has a single register stage, so all lanes are aligned with beat c appearing at c+1.
  - FLUSH is skipped: STREAM goes directly to DONE, and `done` rises at L+1.
  - Intended for single-PE benches and for arrays that skew externally.

## Test plan
- N=4, K=3, `in_valid` held 1, lane i of beat k carries a=16·k+i: `a_row` lane i shows beats 0,1,2 at cycles c0+1+i … c0+3+i. `pe_clr` lane i is high only at c0+1+i. `done` is high exactly at L+4.
- Bubble: K=2 with `in_valid` low for one cycle between the beats. Each lane shows beat0, then a zero with `lane_valid`=0, then beat1. `done` fires one cycle later than in the no-bubble case.
- `start` with `len`=0: stays IDLE, with `busy`=0 and `in_ready`=0 throughout.
- `start` pulsed during STREAM and during DONE: ignored, K unchanged, no extra tile.
- `rst_n` low for one cycle mid-FLUSH: all outputs read 0 immediately, with no `done`. A new tile after reset behaves as in test 1.
- Without `MAC_FEEDER_SKEW_EN`, K=3: all four lanes are identical-time at c0+1 … c0+3, and `done` is at L+1.

Source files
------------

// File: rtl/mac_operand_feeder.sv
// Edge feeder for an NxN MAC array: handshaked beats, per-lane skew, zero-filled bubbles.
// Optional define MAC_FEEDER_SKEW_EN enables the diagonal wavefront skew and FLUSH phase.
module mac_operand_feeder #(
  parameter int W  = 16,
  parameter int N  = 4,
  parameter int LW = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [LW-1:0]  len,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] a_vec,
  input  logic [N*W-1:0] b_vec,
  output logic [N*W-1:0] a_row,
  output logic [N*W-1:0] b_col,
  output logic [N-1:0]   lane_valid,
  output logic [N-1:0]   pe_clr,
  output logic           busy,
  output logic           done
);

`ifdef MAC_FEEDER_SKEW_EN
  localparam bit SKEW = 1'b1;
`else
  localparam bit SKEW = 1'b0;
`endif
  localparam int FW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE, STREAM, FLUSH, DONE
  } state_t;

  state_t state, state_nxt;
  logic [LW-1:0] k_q;
  logic [LW-1:0] cnt_q;
  logic [LW-1:0] cnt_inc;
  logic [FW-1:0] fcnt_q;
  logic          acc;
  logic          last;
  logic          go;
  logic          clr_in;

  assign in_ready = (state == STREAM);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign acc      = in_valid && in_ready;
  assign cnt_inc  = cnt_q + 1'b1;
  assign last     = acc && (cnt_inc == k_q);
  assign go       = (state == IDLE) && start && (len != '0);
  assign clr_in   = acc && (cnt_q == '0);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (go) state_nxt = STREAM;
      STREAM: if (last) state_nxt = (SKEW && N > 1) ? FLUSH : DONE;
      FLUSH:  if (fcnt_q == FW'(N - 2)) state_nxt = DONE;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      k_q    <= '0;
      cnt_q  <= '0;
      fcnt_q <= '0;
    end else begin
      state <= state_nxt;
      if (go) begin
        k_q   <= len;
        cnt_q <= '0;
      end else if (acc) begin
        cnt_q <= cnt_inc;
      end
      fcnt_q <= (state == FLUSH) ? fcnt_q + 1'b1 : '0;
    end
  end

  // Lane i delay: i+1 stages when skewed, otherwise one stage for all lanes
  for (genvar i = 0; i < N; i++) begin : g_lane
    localparam int D = SKEW ? i + 1 : 1;
    logic [D-1:0][W-1:0] a_sr;
    logic [D-1:0][W-1:0] b_sr;
    logic [D-1:0]        v_sr;
    logic [D-1:0]        c_sr;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_sr <= '0;
        b_sr <= '0;
        v_sr <= '0;
        c_sr <= '0;
      end else begin
        a_sr[0] <= acc ? a_vec[i*W +: W] : '0;
        b_sr[0] <= acc ? b_vec[i*W +: W] : '0;
        v_sr[0] <= acc;
        c_sr[0] <= clr_in;
        for (int j = 1; j < D; j++) begin
          a_sr[j] <= a_sr[j-1];
          b_sr[j] <= b_sr[j-1];
          v_sr[j] <= v_sr[j-1];
          c_sr[j] <= c_sr[j-1];
        end
      end
    end

    assign a_row[i*W +: W] = a_sr[D-1];
    assign b_col[i*W +: W] = b_sr[D-1];
    assign lane_valid[i]   = v_sr[D-1];
    assign pe_clr[i]       = c_sr[D-1];
  end

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Scoreboard bench for mac_operand_feeder: random tiles, bubbles, ignored starts, reset.
// Expected lane timing derives from the beat-acceptance cycle and the lane delay.
module tb_mac_operand_feeder;
  localparam int W  = 16;
  localparam int N  = 4;
  localparam int LW = 8;
`ifdef MAC_FEEDER_SKEW_EN
  localparam bit SKEW = 1'b1;
`else
  localparam bit SKEW = 1'b0;
`endif
  localparam int ND = SKEW ? N : 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [LW-1:0]  len = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [N*W-1:0] a_vec = '0;
  logic [N*W-1:0] b_vec = '0;
  logic [N*W-1:0] a_row;
  logic [N*W-1:0] b_col;
  logic [N-1:0]   lane_valid;
  logic [N-1:0]   pe_clr;
  logic           busy;
  logic           done;

  mac_operand_feeder #(.W(W), .N(N), .LW(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_vec(a_vec), .b_vec(b_vec),
    .a_row(a_row), .b_col(b_col),
    .lane_valid(lane_valid), .pe_clr(pe_clr),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          c;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic        clr;
  } beat_t;

  beat_t lq[N][$];
  int    dq[$];
  bit    exp_busy = 1'b0;
  bit    exp_ready = 1'b0;
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string nm, input int ln,
                     input logic [63:0] act, input logic [63:0] ex);
    checks++;
    if (act !== ex) begin
      errors++;
      $display("FAIL %s lane=%0d cyc=%0d got=%0h want=%0h",
               nm, ln, cyc, act, ex);
    end
  endtask

  // Monitor: every cycle each lane either presents its next queued beat or zeros
  always @(negedge clk) begin : mon
    logic [63:0] act;
    logic [63:0] ex;
    logic        e;
    for (int i = 0; i < N; i++) begin
      act = 64'({lane_valid[i], pe_clr[i], a_row[i*W +: W], b_col[i*W +: W]});
      ex = '0;
      if (lq[i].size() > 0 && lq[i][0].c == cyc) begin
        ex = 64'({1'b1, lq[i][0].clr, lq[i][0].a, lq[i][0].b});
        void'(lq[i].pop_front());
      end
      chk("lane", i, act, ex);
    end
    e = 1'b0;
    if (dq.size() > 0 && dq[0] == cyc) begin
      e = 1'b1;
      void'(dq.pop_front());
    end
    chk("done", 0, 64'(done), 64'(e));
    chk("in_ready", 0, 64'(in_ready), 64'(exp_ready));
    chk("busy", 0, 64'(busy), 64'(exp_busy));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) begin
      a_vec[i*W +: W] = W'($urandom);
      b_vec[i*W +: W] = W'($urandom);
    end
  endtask

  // mode 0: always valid, patterned a; 1: random bubbles; 2: one bubble after beat 0
  task automatic run_tile(input int k, input int mode,
                          input bit poke, input bit rst);
    int n;
    int cy;
    int lst;
    bit v;
    n = 0;
    cy = 0;
    lst = 0;
    start = 1'b1;
    len = LW'(k);
    in_valid = 1'b0;
    step();
    start = 1'b0;
    exp_busy = 1'b1;
    exp_ready = 1'b1;
    while (n < k) begin
      case (mode)
        0: v = 1'b1;
        1: v = ($urandom_range(99) >= 30);
        default: v = (cy != 1);
      endcase
      in_valid = v;
      rand_data();
      if (mode == 0)
        for (int i = 0; i < N; i++) a_vec[i*W +: W] = W'(16 * n + i);
      if (poke && cy == 1) begin
        start = 1'b1;
        len = LW'($urandom_range(255, 1));
      end
      if (v) begin
        for (int i = 0; i < N; i++)
          lq[i].push_back('{cyc + 1 + (SKEW ? i : 0),
                            a_vec[i*W +: W], b_vec[i*W +: W], n == 0});
        n++;
        if (n == k) lst = cyc;
      end
      cy++;
      step();
      start = 1'b0;
    end
    exp_ready = 1'b0;
    in_valid = 1'($urandom_range(1));
    rand_data();
    dq.push_back(lst + ND);
    if (rst) begin
      rst_n = 1'b0;
      for (int i = 0; i < N; i++) lq[i].delete();
      dq.delete();
      exp_busy = 1'b0;
      step();
      rst_n = 1'b1;
      in_valid = 1'b0;
      step();
      return;
    end
    for (int f = 0; f < ND - 1; f++) begin
      step();
      in_valid = 1'($urandom_range(1));
      rand_data();
    end
    if (poke) begin
      start = 1'b1;
      len = LW'($urandom_range(255, 1));
    end
    step();
    start = 1'b0;
    in_valid = 1'b0;
    exp_busy = 1'b0;
  endtask

  initial begin
    int left;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    start = 1'b1;
    len = '0;
    repeat (3) step();
    start = 1'b0;
    step();

    run_tile(3, 0, 1'b0, 1'b0);
    run_tile(2, 2, 1'b0, 1'b0);
    run_tile(4, 1, 1'b1, 1'b0);
    run_tile(5, 0, 1'b0, 1'b1);
    run_tile(3, 0, 1'b0, 1'b0);
    repeat (8) run_tile($urandom_range(12, 1), 1, 1'($urandom_range(1)), 1'b0);
    run_tile(255, 1, 1'b0, 1'b0);
    run_tile(1, 0, 1'b1, 1'b0);
    repeat (N + 3) step();

    left = dq.size();
    for (int i = 0; i < N; i++) left += lq[i].size();
    chk("drain", 0, 64'(left), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
